inst_fetch: RTL and testbench



---
 rtl/simple_pkg.sv | 21 ++
 rtl/fetch_skid.sv | 55 +++++
 rtl/inst_fetch.sv | 145 ++++++++++++++
 tb/tb_inst_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE 16-bit core: opcode fields, fetch FSM
// states and instruction classification helpers.
package simple_pkg;

    localparam logic [1:0] OPC_CLASS_ALU = 2'b11;
    localparam logic [3:0] OPC_HLT       = 4'b1111;
    localparam logic [3:0] OPC_OUT       = 4'b1101;
    localparam logic [3:0] OPC_IN        = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // HLT lives in the ALU class with the all-ones minor opcode.
    function automatic logic is_halt(input logic [15:0] inst);
        return (inst[15:14] == OPC_CLASS_ALU) && (inst[7:4] == OPC_HLT);
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry holding buffer for one {instruction, pc} pair that arrives
// from memory while the fetch output register is still occupied.
module fetch_skid #(
    parameter int INST_W = 16,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              full_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o
);

    logic              full_q, full_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   pc_q,   pc_d;

    // Simultaneous push and pop replaces the entry and keeps it full.
    always_comb begin
        full_d = full_q;
        inst_d = inst_q;
        pc_d   = pc_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d = 1'b1;
            inst_d = inst_i;
            pc_d   = pc_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            inst_q <= '0;
            pc_q   <= '0;
        end else begin
            full_q <= full_d;
            inst_q <= inst_d;
            pc_q   <= pc_d;
        end
    end

    assign full_o = full_q;
    assign inst_o = inst_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: drives the synchronous instruction memory,
// presents one instruction per cycle and handles stall, redirect and HLT.
module inst_fetch
    import simple_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic              imem_rd,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              inst_valid,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   f_q, f_d;
    logic              pending_q, pending_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic              out_valid_q, out_valid_d;
    logic [INST_W-1:0] inst_out_q, inst_out_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;

    logic              skid_full;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;
    logic              skid_push, skid_pop, skid_flush;

    logic accept, out_free, hlt_accept, stall_cond, issue;

    assign accept     = out_valid_q && !stall;
    assign out_free   = !out_valid_q || !stall;
    assign hlt_accept = (state_q == RUN) && accept && is_halt(inst_out_q[15:0]);
    // Stop issuing whenever the response could find both output and skid occupied.
    assign stall_cond = stall && (skid_full || (pending_q && out_valid_q));
    assign issue      = (state_q == RUN) && !br_taken && !hlt_accept && !stall_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        f_d         = issue ? f_q + PC_W'(1) : f_q;
        pending_d   = issue;
        pend_pc_d   = issue ? f_q : pend_pc_q;
        out_valid_d = out_valid_q;
        inst_out_d  = inst_out_q;
        pc_out_d    = pc_out_q;
        skid_push   = 1'b0;
        skid_pop    = 1'b0;
        skid_flush  = 1'b0;

        case (state_q)
            IDLE:    if (start && !br_taken) state_d = RUN;
            RUN:     if (hlt_accept) state_d = HALT;
            HALT:    if (start && !br_taken) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (br_taken) begin
            f_d         = br_target;
            pending_d   = 1'b0;
            skid_flush  = 1'b1;
            out_valid_d = 1'b0;
        end else if (hlt_accept) begin
            // Resume point is held in F itself; the next start fetches from it.
            f_d         = pc_out_q + PC_W'(1);
            pending_d   = 1'b0;
            skid_flush  = 1'b1;
            out_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_full) begin
                out_valid_d = 1'b1;
                inst_out_d  = skid_inst;
                pc_out_d    = skid_pc;
                skid_pop    = 1'b1;
                skid_push   = pending_q;
            end else if (pending_q) begin
                out_valid_d = 1'b1;
                inst_out_d  = imem_rdata;
                pc_out_d    = pend_pc_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (pending_q) begin
            skid_push = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q         <= RESET_PC;
            pending_q   <= 1'b0;
            pend_pc_q   <= '0;
            out_valid_q <= 1'b0;
            inst_out_q  <= '0;
            pc_out_q    <= '0;
        end else begin
            f_q         <= f_d;
            pending_q   <= pending_d;
            pend_pc_q   <= pend_pc_d;
            out_valid_q <= out_valid_d;
            inst_out_q  <= inst_out_d;
            pc_out_q    <= pc_out_d;
        end
    end

    fetch_skid #(
        .INST_W (INST_W),
        .PC_W   (PC_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (skid_flush),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .inst_i  (imem_rdata),
        .pc_i    (pend_pc_q),
        .full_o  (skid_full),
        .inst_o  (skid_inst),
        .pc_o    (skid_pc)
    );

    assign imem_rd    = issue;
    assign imem_addr  = f_q;
    assign inst_out   = inst_out_q;
    assign pc_out     = pc_out_q;
    assign inst_valid = out_valid_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected {pc, inst} pairs are queued as
// each run segment is launched and popped whenever an instruction is accepted.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic        inst_valid;
    logic        halted;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    inst_fetch #(.PC_W(16), .INST_W(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst_out   (inst_out),
        .pc_out     (pc_out),
        .inst_valid (inst_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (a == 16'h0007) return 16'hC0F0;
        return a ^ 16'h5A00;
    endfunction

    // Synchronous instruction memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem_val(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [15:0] first, input int count);
        logic [15:0] pc;
        pc = first;
        for (int i = 0; i < count; i++) begin
            sb_q.push_back('{pc: pc, inst: mem_val(pc)});
            pc = pc + 16'd1;
        end
    endtask

    task automatic wait_pc(input logic [15:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (inst_valid && pc_out == pc) found = 1'b1;
            else tick();
        end
        if (!found) check("wait_pc", {16'h0, pc_out}, {16'h0, pc});
    endtask

    task automatic redirect(input logic [15:0] tgt);
        br_taken  = 1'b1;
        br_target = tgt;
        tick();
        br_taken  = 1'b0;
    endtask

    // Accept happens on the coming edge; inputs are stable by the negedge.
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pc", {16'h0, pc_out}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_pc", {16'h0, pc_out}, {16'h0, mon_e.pc});
                check("sb_inst", {16'h0, inst_out}, {16'h0, mon_e.inst});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_imem_rd", {31'h0, imem_rd}, 32'h0);
        check("rst_imem_addr", {16'h0, imem_addr}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_inst_out", {16'h0, inst_out}, 32'h0);
        check("rst_pc_out", {16'h0, pc_out}, 32'h0);

        // Sequential fetch from RESET_PC, with a 3-cycle stall once pc=2 is pending.
        push_seq(16'h0000, 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_rd", {31'h0, imem_rd}, 32'h1);
        check("start_addr0", {16'h0, imem_addr}, 32'h0);
        tick();
        check("lat_no_valid", {31'h0, inst_valid}, 32'h0);
        check("seq_addr1", {16'h0, imem_addr}, 32'h1);
        tick();
        check("lat_first_valid", {31'h0, inst_valid}, 32'h1);
        check("lat_first_pc", {16'h0, pc_out}, 32'h0);
        check("seq_addr2", {16'h0, imem_addr}, 32'h2);
        tick();
        stall = 1'b1;
        #1;
        check("stall_no_fetch", {31'h0, imem_rd}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_pc", {16'h0, pc_out}, 32'h1);
            check("stall_hold_valid", {31'h0, inst_valid}, 32'h1);
            check("stall_no_fetch", {31'h0, imem_rd}, 32'h0);
        end
        stall = 1'b0;
        #1;
        check("release_addr3", {16'h0, imem_addr}, 32'h3);
        check("release_rd", {31'h0, imem_rd}, 32'h1);

        // Redirect while pc=5 presented and pc=6 pending.
        wait_pc(16'h0005);
        redirect(16'h0040);
        check("br_bubble", {31'h0, inst_valid}, 32'h0);
        check("br_fetch_addr", {16'h0, imem_addr}, 32'h40);
        check("sb_drained_seg1", sb_q.size(), 32'h0);
        push_seq(16'h0040, 3);
        tick();
        check("br_bubble2", {31'h0, inst_valid}, 32'h0);
        tick();
        check("br_lat_valid", {31'h0, inst_valid}, 32'h1);
        check("br_lat_pc", {16'h0, pc_out}, 32'h40);

        // Jump to the HLT at pc=7 and halt on it.
        wait_pc(16'h0042);
        redirect(16'h0007);
        check("sb_drained_seg2", sb_q.size(), 32'h0);
        push_seq(16'h0007, 1);
        wait_pc(16'h0007);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("hlt_halted", {31'h0, halted}, 32'h1);
            check("hlt_no_fetch", {31'h0, imem_rd}, 32'h0);
            check("hlt_no_valid", {31'h0, inst_valid}, 32'h0);
            tick();
        end
        check("sb_drained_hlt", sb_q.size(), 32'h0);

        // Resume after HLT at pc+1.
        push_seq(16'h0008, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("resume_halted", {31'h0, halted}, 32'h0);
        check("resume_rd", {31'h0, imem_rd}, 32'h1);
        check("resume_addr", {16'h0, imem_addr}, 32'h8);

        // PC wraparound 0xFFFF -> 0x0000.
        wait_pc(16'h000B);
        redirect(16'hFFFE);
        check("sb_drained_seg3", sb_q.size(), 32'h0);
        push_seq(16'hFFFE, 3);
        wait_pc(16'h0001);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wrap_stall_pc", {16'h0, pc_out}, 32'h1);
            check("wrap_stall_no_fetch", {31'h0, imem_rd}, 32'h0);
        end
        check("sb_drained_wrap", sb_q.size(), 32'h0);

        // Asynchronous reset while stalled with the skid full.
        rst = 1'b1;
        #1;
        check("arst_valid", {31'h0, inst_valid}, 32'h0);
        check("arst_inst", {16'h0, inst_out}, 32'h0);
        check("arst_pc", {16'h0, pc_out}, 32'h0);
        check("arst_halted", {31'h0, halted}, 32'h0);
        check("arst_rd", {31'h0, imem_rd}, 32'h0);
        check("arst_addr", {16'h0, imem_addr}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        stall = 1'b0;
        push_seq(16'h0000, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_addr", {16'h0, imem_addr}, 32'h0);
        check("restart_rd", {31'h0, imem_rd}, 32'h1);
        wait_pc(16'h0003);
        tick();
        check("sb_drained_final", sb_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
